// File: rtl/chacha_pkg.sv
// Shared constants for the ChaCha20 plaintext path and the assembler state encoding.
package chacha_pkg;

  localparam int WORD_W    = 8;
  localparam int NUM_WORDS = 4;
  localparam int BLK_W     = WORD_W * NUM_WORDS;

  typedef enum logic {
    COLLECT = 1'b0,
    FULL    = 1'b1
  } asm_state_t;

endpackage

// File: rtl/bit_event_sync.sv
// Brings the asynchronous bit_flag/bit_value pair into the clk domain and turns each
// rising edge of bit_flag into a single-cycle event carrying the aligned bit value.
module bit_event_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic bit_flag,
  input  logic bit_value,
  output logic ev,
  output logic ev_value
);

  logic flag_s1;
  logic flag_s2;
  logic flag_s3;
  logic value_s1;
  logic value_s2;

  // Two-flop synchronisers for flag and value, plus a delayed flag copy for edge detect.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flag_s1  <= 1'b0;
      flag_s2  <= 1'b0;
      flag_s3  <= 1'b0;
      value_s1 <= 1'b0;
      value_s2 <= 1'b0;
    end else begin
      flag_s1  <= bit_flag;
      flag_s2  <= flag_s1;
      flag_s3  <= flag_s2;
      value_s1 <= bit_value;
      value_s2 <= value_s1;
    end
  end

  // value_s2 has the same synchroniser depth as flag_s2, so it is the value that
  // accompanied the flag edge.
  assign ev       = flag_s2 & ~flag_s3;
  assign ev_value = value_s2;

endmodule

// File: rtl/plaintext_block_assembler.sv
// Collects synchronised plaintext bits MSB-first into a block and hands the completed
// block to the XOR/keystream stage over valid/ready. Extra bits while full set overrun.
module plaintext_block_assembler #(
  parameter  int WORD_W    = chacha_pkg::WORD_W,
  parameter  int NUM_WORDS = chacha_pkg::NUM_WORDS,
  localparam int BLK_W     = WORD_W * NUM_WORDS,
  localparam int CNT_W     = $clog2(BLK_W + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             bit_flag,
  input  logic             bit_value,
  input  logic             clear,
  output logic [BLK_W-1:0] pt_block,
  output logic             pt_valid,
  input  logic             pt_ready,
  output logic [CNT_W-1:0] bit_count,
  output logic             overrun
);

  import chacha_pkg::*;

  asm_state_t       state;
  asm_state_t       state_n;
  logic [BLK_W-1:0] block_n;
  logic [CNT_W-1:0] count_n;
  logic             valid_n;
  logic             overrun_n;
  logic             ev;
  logic             ev_value;

  bit_event_sync u_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_flag (bit_flag),
    .bit_value(bit_value),
    .ev       (ev),
    .ev_value (ev_value)
  );

  // State and all outputs are registered; next values come from the decode below.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= COLLECT;
      pt_block  <= '0;
      pt_valid  <= 1'b0;
      bit_count <= '0;
      overrun   <= 1'b0;
    end else begin
      state     <= state_n;
      pt_block  <= block_n;
      pt_valid  <= valid_n;
      bit_count <= count_n;
      overrun   <= overrun_n;
    end
  end

  // Next-state decode with priority clear > handshake > bit event.
  always_comb begin
    state_n   = state;
    block_n   = pt_block;
    count_n   = bit_count;
    valid_n   = pt_valid;
    overrun_n = overrun;
    if (clear) begin
      state_n   = COLLECT;
      block_n   = '0;
      count_n   = '0;
      valid_n   = 1'b0;
      overrun_n = 1'b0;
    end else begin
      case (state)
        COLLECT: begin
          if (ev) begin
            block_n = {pt_block[BLK_W-2:0], ev_value};
            count_n = bit_count + CNT_W'(1);
            if (bit_count == CNT_W'(BLK_W - 1)) begin
              state_n = FULL;
              valid_n = 1'b1;
            end
          end
        end
        FULL: begin
          // A bit arriving while the block is held is lost, even on the accept cycle.
          if (ev) begin
            overrun_n = 1'b1;
          end
          if (pt_ready) begin
            state_n = COLLECT;
            block_n = '0;
            count_n = '0;
            valid_n = 1'b0;
          end
        end
        default: begin
          state_n = COLLECT;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_plaintext_block_assembler.sv
// Bench for plaintext_block_assembler: directed scenarios followed by random traffic,
// with a bit-queue reference model and a handshake scoreboard.
module tb_plaintext_block_assembler;

  localparam int BLK_W = 32;
  localparam int CNT_W = 6;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             bit_flag = 1'b0;
  logic             bit_value = 1'b0;
  logic             clear = 1'b0;
  logic             pt_ready = 1'b0;
  logic [BLK_W-1:0] pt_block;
  logic             pt_valid;
  logic [CNT_W-1:0] bit_count;
  logic             overrun;

  always #5 clk = ~clk;

  plaintext_block_assembler dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bit_flag (bit_flag),
    .bit_value(bit_value),
    .clear    (clear),
    .pt_block (pt_block),
    .pt_valid (pt_valid),
    .pt_ready (pt_ready),
    .bit_count(bit_count),
    .overrun  (overrun)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: the bits currently held, a full flag, the sticky overrun flag,
  // and the blocks expected to be handed over.
  bit               m_bits[$];
  bit               m_full = 1'b0;
  bit               m_ovr = 1'b0;
  logic [BLK_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [BLK_W-1:0] model_value();
    logic [BLK_W-1:0] v = '0;
    foreach (m_bits[i]) v = (v << 1) | BLK_W'(m_bits[i]);
    return v;
  endfunction

  task automatic model_bit(input bit v);
    if (m_full) begin
      m_ovr = 1'b1;
    end else begin
      m_bits.push_back(v);
      if (m_bits.size() == BLK_W) begin
        exp_q.push_back(model_value());
        m_full = 1'b1;
      end
    end
  endtask

  task automatic model_accept();
    if (m_full) begin
      m_full = 1'b0;
      m_bits.delete();
    end
  endtask

  task automatic model_clear();
    if (m_full) void'(exp_q.pop_back());
    m_full = 1'b0;
    m_bits.delete();
    m_ovr = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_count"}, 64'(bit_count), 64'(m_bits.size()));
    chk({tag, "_valid"}, 64'(pt_valid), 64'(m_full));
    chk({tag, "_overrun"}, 64'(overrun), 64'(m_ovr));
    chk({tag, "_block"}, 64'(pt_block), 64'(model_value()));
  endtask

  // Flag held for two samples, then low long enough for the event to drain.
  // The value is inverted once the flag drops, so only the aligned sample is valid.
  task automatic enter_bit(input bit v);
    bit_flag  = 1'b1;
    bit_value = v;
    tick();
    tick();
    bit_flag  = 1'b0;
    bit_value = ~v;
    repeat (3) tick();
    model_bit(v);
  endtask

  task automatic ready_pulse();
    pt_ready = 1'b1;
    tick();
    pt_ready = 1'b0;
    model_accept();
  endtask

  task automatic clear_pulse();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    model_clear();
  endtask

  // Scoreboard monitor: every accepted block must match the oldest expected block.
  always @(negedge clk) begin
    if (rst_n && pt_valid && pt_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL handshake_unexpected: got block %0h, expected no block", pt_block);
      end else begin
        chk("handshake_block", 64'(pt_block), 64'(exp_q.pop_front()));
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [BLK_W-1:0] pat;
    bit               v;
    int               r;

    // 1: reset with flag held high, then exactly one event after release.
    bit_flag  = 1'b1;
    bit_value = 1'b1;
    repeat (3) tick();
    chk("rst_block", 64'(pt_block), 64'h0);
    chk("rst_valid", 64'(pt_valid), 64'h0);
    chk("rst_count", 64'(bit_count), 64'h0);
    chk("rst_overrun", 64'(overrun), 64'h0);
    rst_n = 1'b1;
    tick();
    chk("lat_edge_n", 64'(bit_count), 64'h0);
    tick();
    chk("lat_edge_n1", 64'(bit_count), 64'h0);
    tick();
    chk("lat_edge_n2", 64'(bit_count), 64'h1);
    repeat (5) tick();
    chk("held_flag_single_ev", 64'(bit_count), 64'h1);
    bit_flag = 1'b0;
    repeat (3) tick();
    model_bit(1'b1);
    check_state("t1");

    // 2: known 32-bit pattern, downstream not ready.
    clear_pulse();
    pat = 32'hB000_0001;
    for (int i = BLK_W - 1; i >= 0; i--) enter_bit(pat[i]);
    check_state("t2");
    chk("t2_block_const", 64'(pt_block), 64'hB000_0001);
    chk("t2_count_full", 64'(bit_count), 64'd32);

    // 3: bits while full are dropped and flagged; accept keeps overrun.
    for (int i = 0; i < 3; i++) enter_bit(1'($urandom));
    chk("t3_block_frozen", 64'(pt_block), 64'hB000_0001);
    chk("t3_overrun", 64'(overrun), 64'h1);
    chk("t3_count", 64'(bit_count), 64'd32);
    ready_pulse();
    chk("t3_valid_after_accept", 64'(pt_valid), 64'h0);
    chk("t3_count_after_accept", 64'(bit_count), 64'h0);
    chk("t3_overrun_sticky", 64'(overrun), 64'h1);

    // 4: clear coincides with the sixth event.
    for (int i = 0; i < 5; i++) enter_bit(1'($urandom));
    check_state("t4_pre");
    bit_flag  = 1'b1;
    bit_value = 1'b1;
    tick();
    tick();
    clear    = 1'b1;
    bit_flag = 1'b0;
    tick();
    clear = 1'b0;
    repeat (3) tick();
    model_clear();
    chk("t4_count", 64'(bit_count), 64'h0);
    chk("t4_block", 64'(pt_block), 64'h0);
    chk("t4_overrun", 64'(overrun), 64'h0);

    // 5: accept cycle coincides with an event.
    for (int i = 0; i < BLK_W; i++) enter_bit(1'($urandom));
    check_state("t5_full");
    v         = 1'($urandom);
    bit_flag  = 1'b1;
    bit_value = v;
    tick();
    tick();
    pt_ready = 1'b1;
    bit_flag = 1'b0;
    tick();
    pt_ready = 1'b0;
    repeat (3) tick();
    model_bit(v);
    model_accept();
    check_state("t5_after");
    chk("t5_overrun", 64'(overrun), 64'h1);
    enter_bit(1'($urandom));
    chk("t5_restart_count", 64'(bit_count), 64'h1);
    check_state("t5_restart");

    // 6: asynchronous reset mid-block.
    for (int i = 0; i < 16; i++) enter_bit(1'($urandom));
    chk("t6_count17", 64'(bit_count), 64'd17);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_async_count", 64'(bit_count), 64'h0);
    chk("t6_async_block", 64'(pt_block), 64'h0);
    chk("t6_async_valid", 64'(pt_valid), 64'h0);
    chk("t6_async_overrun", 64'(overrun), 64'h0);
    m_bits.delete();
    m_full = 1'b0;
    m_ovr  = 1'b0;
    exp_q.delete();
    tick();
    rst_n = 1'b1;
    tick();
    check_state("t6_released");

    // Random traffic: mostly bits, with occasional accepts and clears.
    for (int n = 0; n < 200; n++) begin
      r = int'($urandom_range(0, 99));
      if (r < 85) enter_bit(1'($urandom));
      else if (r < 96) ready_pulse();
      else clear_pulse();
      check_state("rnd");
    end
    if (m_full) ready_pulse();
    tick();
    chk("scoreboard_drained", 64'(exp_q.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
